// File: rtl/lcd_driver.sv
// rtl/lcd_driver.sv - HD44780 16x2 LCD driver: power-up init plus 32-character frame writer
module lcd_driver #(
    parameter int PWR_WAIT  = 750000,
    parameter int EN_CYCLES = 16,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ASCII [31:0],
    input  logic       UpdateLCD,
    output logic       LCDBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    // One shared counter, wide enough for the longest interval
    localparam int M1   = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int M2   = (M1 > CMD_WAIT) ? M1 : CMD_WAIT;
    localparam int MAXP = (M2 > EN_CYCLES) ? M2 : EN_CYCLES;
    localparam int CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] TWO_LAST = CW'(1);

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
    } state_t;

    typedef enum logic [1:0] {P_SETUP, P_ENH, P_HOLD, P_WAIT} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    idx_q;
    logic [7:0]    frame_q [31:0];

    logic          byte_st;
    logic [7:0]    cur_byte;
    logic          cur_rs;
    logic [CW-1:0] phase_last;
    logic          phase_end;
    logic          byte_done;

    // Byte currently being presented on the bus, and how long each phase lasts
    always_comb begin
        byte_st    = (state_q != S_PWR) && (state_q != S_IDLE);
        cur_byte   = 8'h00;
        cur_rs     = 1'b0;
        case (state_q)
            S_INIT: begin
                case (idx_q)
                    4'd0, 4'd1, 4'd2: cur_byte = 8'h38;
                    4'd3:             cur_byte = 8'h0C;
                    4'd4:             cur_byte = 8'h01;
                    default:          cur_byte = 8'h06;
                endcase
            end
            S_ADDR1: cur_byte = 8'h80;
            S_LINE1: begin
                cur_byte = frame_q[{1'b0, idx_q}];
                cur_rs   = 1'b1;
            end
            S_ADDR2: cur_byte = 8'hC0;
            S_LINE2: begin
                cur_byte = frame_q[{1'b1, idx_q}];
                cur_rs   = 1'b1;
            end
            default: cur_byte = 8'h00;
        endcase
        case (phase_q)
            P_SETUP: phase_last = TWO_LAST;
            P_ENH:   phase_last = EN_LAST;
            P_HOLD:  phase_last = TWO_LAST;
            default: phase_last = (cur_byte == 8'h01 && !cur_rs) ? CLR_LAST : CMD_LAST;
        endcase
        phase_end = (cnt_q == phase_last);
        byte_done = byte_st && (phase_q == P_WAIT) && phase_end;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_PWR;
        else       state_q <= state_d;
    end

    // Next-state logic: each command/data state advances when its last byte completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PWR:   if (cnt_q == PWR_LAST)              state_d = S_INIT;
            S_INIT:  if (byte_done && idx_q == 4'd5)     state_d = S_IDLE;
            S_IDLE:  if (UpdateLCD)                      state_d = S_ADDR1;
            S_ADDR1: if (byte_done)                      state_d = S_LINE1;
            S_LINE1: if (byte_done && idx_q == 4'd15)    state_d = S_ADDR2;
            S_ADDR2: if (byte_done)                      state_d = S_LINE2;
            S_LINE2: if (byte_done && idx_q == 4'd15)    state_d = S_IDLE;
            default:                                     state_d = S_PWR;
        endcase
    end

    // Phase/cycle/byte-index counters restart on every state entry; frame snapshot taken on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= P_SETUP;
            idx_q   <= 4'd0;
            for (int i = 0; i < 32; i++) frame_q[i] <= 8'h00;
        end else begin
            if (state_q == S_IDLE && UpdateLCD) frame_q <= ASCII;
            if (state_d != state_q) begin
                cnt_q   <= '0;
                phase_q <= P_SETUP;
                idx_q   <= 4'd0;
            end else if (byte_st) begin
                if (phase_end) begin
                    cnt_q   <= '0;
                    phase_q <= phase_t'(phase_q + 2'd1);
                    if (phase_q == P_WAIT) idx_q <= idx_q + 4'd1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (state_q == S_PWR) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Pin outputs decoded from state and phase; DATA/RS only move when a new byte's SETUP begins
    always_comb begin
        LCDBusy  = (state_q != S_IDLE);
        LCD_EN   = byte_st && (phase_q == P_ENH);
        LCD_RS   = byte_st && cur_rs;
        LCD_DATA = byte_st ? cur_byte : 8'h00;
    end

    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

endmodule

// File: doc/lcd_driver.md
Name: lcd_driver

Overview:
- Consumer end of the 32-character LCD text interface: accepts a 32-byte ASCII frame plus an update strobe from the score/display logic and writes it to the board's HD44780-compatible 16x2 character LCD.
- Performs the power-up init sequence itself.
- Reports LCDBusy back to the frame producer.
- Sits between the score block and the LCD pins at the top level.

Parameters:
- PWR_WAIT, 750000: clk cycles idle after reset before the first command (15 ms @ 50 MHz).
- EN_CYCLES, 16: clk cycles LCD_EN is held high per byte.
- CMD_WAIT, 2000: clk cycles waited after each normal byte (40 us).
- CLR_WAIT, 82000: clk cycles waited after the clear-display command (1.64 ms).

Ports:
- clk  in  1  master 50 MHz clock
- reset  in  1  synchronous, active-high reset
- ASCII  in  [7:0] x 32 (unpacked [31:0])  frame; ASCII[0..15] = line 1 col 0..15, ASCII[16..31] = line 2 col 0..15
- UpdateLCD  in  1  request to display the current ASCII frame
- LCDBusy  out  1  high while initialising or writing a frame
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  0 = command, 1 = character data
- LCD_RW  out  1  constant 0 (write only)
- LCD_EN  out  1  LCD enable strobe
- LCD_ON  out  1  constant 1
- LCD_BLON  out  1  constant 1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising clk edge.
- Reset values:
  - LCDBusy = 1, LCD_EN = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00, LCD_ON = 1, LCD_BLON = 1.
  - FSM enters PWR; all counters and the frame latch are cleared.
  - Reset asserted mid-init or mid-frame aborts immediately: EN drops the next edge and the full init sequence is repeated.
- Byte-write sub-sequence, total EN_CYCLES + 4 + WAIT cycles:
  - SETUP: 2 cycles with RS/DATA stable and EN = 0.
  - ENH: EN_CYCLES cycles with EN = 1.
  - HOLD: 2 cycles with EN = 0 and RS/DATA still stable.
  - WAIT: WAIT cycles. WAIT = CLR_WAIT for byte 0x01, CMD_WAIT otherwise.
  - RS/DATA change only at the start of SETUP.
- Main FSM:
  - PWR: count PWR_WAIT cycles, then INIT.
  - INIT: write commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order (RS = 0), then IDLE.
  - IDLE: LCDBusy = 0. If UpdateLCD = 1 on an edge, latch all 32 ASCII bytes into an internal frame and go to ADDR1. LCDBusy = 1 from the next cycle.
  - ADDR1: command 0x80.
  - LINE1: data bytes frame[0..15], RS = 1.
  - ADDR2: command 0xC0.
  - LINE2: data bytes frame[16..31], then IDLE.
- Frame timing:
  - A frame is exactly 34 byte writes = 34*(EN_CYCLES+4+CMD_WAIT) cycles.
  - LCDBusy falls the cycle IDLE is re-entered.
- Init timing: LCDBusy first falls exactly PWR_WAIT + 5*(EN_CYCLES+4+CMD_WAIT) + (EN_CYCLES+4+CLR_WAIT) cycles after reset deasserts.
- Request rules:
  - UpdateLCD is sampled only in IDLE. Pulses while LCDBusy = 1 are ignored and not queued; the producer must wait for LCDBusy = 0.
  - A level held high in IDLE starts a new frame on each return to IDLE.
  - ASCII changes after acceptance do not affect the frame in progress; the snapshot is used.
- Bytes are passed through unmodified; there is no filtering of non-printable codes.
- Counters are sized for the largest parameter. No wrap-around occurs, since every counter is reset at each state entry.

Test Plan:
- Use PWR_WAIT = 20, EN_CYCLES = 4, CMD_WAIT = 10, CLR_WAIT = 30 for all scenarios.
- Init: release reset, hold UpdateLCD = 0. Required response:
  - 6 EN pulses carrying DATA 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS = 0.
  - Each EN high exactly 4 cycles.
  - LCDBusy falls exactly 148 cycles after reset release; LCD_RW = 0 throughout.
- Frame: load ASCII = "P1:0 P2:0 LVL 0 " / "HUMAN  vs  AI   ", pulse UpdateLCD 1 cycle in IDLE. Required response:
  - LCDBusy rises next cycle.
  - 34 EN pulses: 0x80 (RS = 0), 16 line-1 bytes (RS = 1), 0xC0 (RS = 0), 16 line-2 bytes (RS = 1).
  - LCDBusy low exactly 612 cycles after acceptance.
- Setup/hold: on every EN pulse of the frame, LCD_DATA and LCD_RS are stable from 2 cycles before EN rises to 2 cycles after EN falls.
- Snapshot and ignored request:
  - Change ASCII[5] from 0x30 to 0x31 mid-frame → the original 0x30 is written.
  - Pulse UpdateLCD mid-frame → no extra frame; IDLE is reached after 34 writes.
- Reset mid-frame: assert reset during the 10th data byte. Required response:
  - Next cycle LCD_EN = 0, LCDBusy = 1, DATA = 0x00.
  - After release, the full 148-cycle init repeats before IDLE.
